// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin arbiter that lets NUM_REQ valid/ready producers share the single
// write port of an 8-bit synchronous FIFO. One producer is granted at a time.
// A grant lasts for up to MAX_BURST accepted beats. Accepted bytes reach the
// FIFO one cycle after the handshake. Producers are throttled on the FIFO
// almost-full flag, so a full FIFO never receives a write.
//
// Ports:
//   clk          rising-edge clock, shared with the FIFO
//   rst          synchronous, active-high reset
//   req_valid    per-producer data valid
//   req_data     flattened producer data, producer i at [i*DATA_W +: DATA_W]
//   req_ready    per-producer ready (combinational)
//   fifo_afull   FIFO almost-full (2 or fewer free entries)
//   fifo_win_en  FIFO write enable (registered)
//   fifo_din     FIFO write data (registered)
//   grant_id     currently granted producer, meaningful while busy=1
//   busy         high while a producer holds the grant
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter  int NUM_REQ   = 4,
  parameter  int DATA_W    = 8,
  parameter  int MAX_BURST = 4,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fifo_afull,
  output logic                      fifo_win_en,
  output logic [DATA_W-1:0]         fifo_din,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    cur_q, cur_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               cur_valid;
  logic [DATA_W-1:0]  cur_data;
  logic [ID_W-1:0]    pick;
  logic               transfer;
  int                 idx;

  // Select the granted producer's valid and data.
  // NOTE: every signal driven in an always_comb gets a default on entry, so
  // no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    cur_valid = 1'b0;
    cur_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (cur_q == ID_W'(i)) begin
        cur_valid = req_valid[i];
        cur_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Round-robin search starting just after the last released producer.
  // Offsets are walked from lowest to highest priority so the nearest
  // requester overwrites any farther one. The modulo keeps the search
  // correct for non-power-of-2 NUM_REQ.
  always_comb begin
    pick = '0;
    idx  = 0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = (int'(last_q) + off) % NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i == idx && req_valid[i]) begin
          pick = ID_W'(i);
        end
      end
    end
  end

  // Next-state and handshake logic.
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    req_ready = '0;
    transfer  = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          cur_d   = pick;
          cnt_d   = '0;
          state_d = BURST;
        end
      end

      BURST: begin
        req_ready[cur_q] = !fifo_afull;
        transfer         = cur_valid && !fifo_afull;
        if (!cur_valid) begin
          // Producer withdrew; release even if the FIFO is throttling.
          state_d = IDLE;
          last_d  = cur_q;
        end else if (transfer) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(MAX_BURST - 1)) begin
            state_d = IDLE;
            last_d  = cur_q;
          end
        end
        // A valid producer stalled by almost-full holds the grant with
        // cnt_q unchanged; there is deliberately no timeout.
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      last_q      <= ID_W'(NUM_REQ - 1);
      cnt_q       <= '0;
      fifo_win_en <= 1'b0;
      fifo_din    <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      fifo_win_en <= transfer;
      if (transfer) begin
        fifo_din <= cur_data;
      end
    end
  end

  assign busy     = (state_q == BURST);
  assign grant_id = cur_q;

endmodule
